// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder.
//   mem_state_t : responder FSM states (IDLE, WAIT, BEAT)
//   BURST_LEN   : beats in a line-fill burst
//   LINE_BYTES  : bytes per cache line (burst wrap boundary)
//   CNT_W       : width of the latency counter
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } mem_state_t;

    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned LINE_BYTES = 8;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous 16-bit word RAM with a one-cycle
// registered read. Contents are not reset.
//   clk   : clock
//   we    : write enable (write happens on the rising edge)
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered, valid the cycle after addr is presented
module mem_array #(
    parameter  int unsigned DEPTH = 32768,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle, single-outstanding data memory responder.
// Accepts load/store requests on a valid/ready channel and answers on a
// valid-only response channel LATENCY cycles after accept. Stores commit
// on the accept edge; loads read the array one cycle before each beat.
// Optional feature macro: MEM_BURST_EN enables 4-word critical-word-first
// burst loads (req_burst); without it every load is a single beat.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake
//   req_wr, req_burst     : store flag, burst-load flag
//   req_addr, req_wdata   : byte address (bit 0 ignored), store data
//   rsp_valid, rsp_wr     : beat valid, beat is a store acknowledge
//   rsp_last, rsp_rdata   : final beat of transaction, load data
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 2 ** (ADDR_W - 1),
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic              rsp_last,
    output logic [15:0]       rsp_rdata
);

    localparam int unsigned IW = ADDR_W - 1;
    localparam int unsigned AW = $clog2(DEPTH);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_wr_q, rsp_wr_d;
    logic             rsp_last_q, rsp_last_d;
    // Holds req_ready low until the first edge after reset release.
    logic             live_q;

`ifdef MEM_BURST_EN
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES) - 1;
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    logic              burst_q, burst_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              unused_in;
    assign unused_in = req_addr[0];
`else
    logic              unused_in;
    assign unused_in = req_addr[0] ^ req_burst;
`endif

    logic          accept;
    logic          mem_we;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;

    assign req_ready = live_q & ((state_q == IDLE) | rsp_last_q);
    assign accept    = req_valid & req_ready;
    assign mem_addr  = AW'(32'(rd_idx) % DEPTH);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_wr_d    = 1'b0;
        rsp_last_d  = 1'b0;
        mem_we      = 1'b0;
        rd_idx      = idx_q;
`ifdef MEM_BURST_EN
        burst_d     = burst_q;
        beat_d      = beat_q;
`endif

        unique case (state_q)
            IDLE: ;
            WAIT: begin
                // Counter hits zero on the same edge that enters BEAT; the
                // array read for the first beat is issued on that edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = BEAT;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = wr_q;
`ifdef MEM_BURST_EN
                    rsp_last_d  = ~burst_q;
`else
                    rsp_last_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BEAT: begin
                state_d = IDLE;
`ifdef MEM_BURST_EN
                if (!rsp_last_q) begin
                    // Next word within the aligned line, wrapping.
                    state_d     = BEAT;
                    beat_d      = beat_q + BEAT_W'(1);
                    idx_d       = {idx_q[IW-1:OFF_W], idx_q[OFF_W-1:0] + OFF_W'(1)};
                    rd_idx      = idx_d;
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = wr_q;
                    rsp_last_d  = (beat_q == BEAT_W'(BURST_LEN - 2));
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // An accept can only occur in IDLE or the final beat, so it
        // overrides whatever the case above chose.
        if (accept) begin
            idx_d  = req_addr[ADDR_W-1:1];
            wr_d   = req_wr;
            mem_we = req_wr;
            rd_idx = req_addr[ADDR_W-1:1];
`ifdef MEM_BURST_EN
            burst_d = req_burst & ~req_wr;
            beat_d  = '0;
`endif
            if (LATENCY == 1) begin
                state_d     = BEAT;
                rsp_valid_d = 1'b1;
                rsp_wr_d    = req_wr;
`ifdef MEM_BURST_EN
                rsp_last_d  = ~(req_burst & ~req_wr);
`else
                rsp_last_d  = 1'b1;
`endif
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
            live_q      <= 1'b0;
`ifdef MEM_BURST_EN
            burst_q     <= 1'b0;
            beat_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_last_q  <= rsp_last_d;
            live_q      <= 1'b1;
`ifdef MEM_BURST_EN
            burst_q     <= burst_d;
            beat_q      <= beat_d;
`endif
        end
    end

    mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_last  = rsp_last_q;
    // Array data is only exposed on load beats.
    assign rsp_rdata = (rsp_valid_q & ~rsp_wr_q) ? mem_rdata : '0;

endmodule
